// File: rtl/adc_pack_ctr.sv
// ADC capture front end: packs eight 16-bit sample slots into 128-bit FIFO words under arm/trigger control.
// Optional build macro ADC_TEST_PATTERN_EN replaces samples with an internal ramp counter.
module adc_pack_ctr #(
  parameter int ADC_WIDTH = 12,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 ui_clk,
  input  logic                 ui_rst,
  input  logic [ADC_WIDTH-1:0] adc_data_i,
  input  logic                 adc_valid_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic                 trig_mode_i,
  input  logic                 trig_i,
  input  logic [CNT_WIDTH-1:0] cap_words_i,
  input  logic                 W0_full_i,
  output logic                 W0_wren_o,
  output logic [127:0]         W0_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 ovf_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cap_q;
  logic                 mode_q;
  logic                 trig_q;
  logic [2:0]           slot_cnt;
  logic [111:0]         pack_p0;
  logic [15:0]          sample;
  logic [CNT_WIDTH-1:0] word_next;
  logic                 take;

  function automatic logic [15:0] zero_extend(input logic [ADC_WIDTH-1:0] s);
    return 16'(s);
  endfunction

  assign take      = (state == CAPTURE) && adc_valid_i && !abort_i;
  assign word_next = word_cnt_o + 1'b1;

`ifdef ADC_TEST_PATTERN_EN
  logic [15:0] pat_cnt;

  always_ff @(posedge ui_clk) begin
    if (ui_rst)
      pat_cnt <= '0;
    else if (state == IDLE && arm_i)
      pat_cnt <= '0;
    else if (take)
      pat_cnt <= pat_cnt + 16'd1;
  end

  assign sample = pat_cnt;
`else
  assign sample = zero_extend(adc_data_i);
`endif

  // Slots 0..6 accumulate here; slot 7 goes straight into the output word.
  always_ff @(posedge ui_clk) begin
    for (int k = 0; k < 7; k++)
      if (take && slot_cnt == 3'(k))
        pack_p0[16*k +: 16] <= sample;
  end

  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      state      <= IDLE;
      cap_q      <= '0;
      mode_q     <= 1'b0;
      trig_q     <= 1'b0;
      slot_cnt   <= '0;
      W0_wren_o  <= 1'b0;
      W0_data_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ovf_o      <= 1'b0;
      word_cnt_o <= '0;
    end else begin
      trig_q    <= trig_i;
      W0_wren_o <= 1'b0;
      done_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (arm_i) begin
            cap_q      <= cap_words_i;
            mode_q     <= trig_mode_i;
            ovf_o      <= 1'b0;
            word_cnt_o <= '0;
            slot_cnt   <= '0;
            busy_o     <= 1'b1;
            state      <= ARMED;
          end
        end
        ARMED: begin
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (!mode_q || (trig_i && !trig_q)) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (abort_i) begin
            slot_cnt <= '0;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end else if (adc_valid_i) begin
            slot_cnt <= slot_cnt + 3'd1;
            if (slot_cnt == 3'd7) begin
              // A dropped word still counts: capture length is measured in time.
              if (W0_full_i) begin
                ovf_o <= 1'b1;
              end else begin
                W0_wren_o <= 1'b1;
                W0_data_o <= {sample, pack_p0};
              end
              word_cnt_o <= word_next;
              if (cap_q != '0 && word_next == cap_q) begin
                busy_o <= 1'b0;
                done_o <= 1'b1;
                state  <= DONE;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_pack_ctr.sv
// Directed bench for adc_pack_ctr: vector table of bounded captures plus trigger, wrap and reset sequences.
module tb_adc_pack_ctr;
  localparam int AW = 12;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] adc_data;
  logic          adc_valid, arm, abort_r, trig_mode, trig, full;
  logic [CW-1:0] cap_words;
  logic          wren, busy, done, ovf;
  logic [127:0]  wdata;
  logic [CW-1:0] word_cnt;

  always #5 clk = ~clk;

  adc_pack_ctr #(.ADC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .ui_clk(clk), .ui_rst(rst), .adc_data_i(adc_data), .adc_valid_i(adc_valid),
    .arm_i(arm), .abort_i(abort_r), .trig_mode_i(trig_mode), .trig_i(trig),
    .cap_words_i(cap_words), .W0_full_i(full), .W0_wren_o(wren), .W0_data_o(wdata),
    .busy_o(busy), .done_o(done), .ovf_o(ovf), .word_cnt_o(word_cnt)
  );

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0, done_cnt = 0, done_wr = 0;
  logic [127:0] wr_log [256];

  always @(negedge clk) begin
    if (wren) begin
      wr_log[wr_cnt % 256] = wdata;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      if (wren) done_wr++;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_word(input int idx);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = 16'(idx*8 + k + 1);
    return r;
  endfunction

  typedef struct {
    int cap; int nsamp; int full_word; bit do_abort;
    int exp_wr; int exp_done; int exp_done_wr; int exp_wcnt; bit exp_ovf; int last_idx;
  } vec_t;

  vec_t tbl [5];

  task automatic arm_capture(input bit mode, input int cap);
    @(negedge clk); arm = 1'b1; trig_mode = mode; cap_words = CW'(cap);
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic feed(input int n, input int full_at);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      adc_valid = 1'b1;
      adc_data  = AW'(s + 1);
      full      = (s == full_at);
    end
    @(negedge clk); adc_valid = 1'b0; full = 1'b0;
  endtask

  initial begin
    int w0, d0, dw0;
    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; arm = 1'b0; abort_r = 1'b0;
    trig_mode = 1'b0; trig = 1'b0; full = 1'b0; cap_words = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_wren", wren, 0);
    check("rst_data", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_wcnt", word_cnt, 0);

    //          cap nsamp full abort wr done dwr wcnt ovf last
    tbl[0] = '{2,  16,  -1,  0,    2,  1,   1,  2,   0,  1};
    tbl[1] = '{3,  24,   1,  0,    2,  1,   1,  3,   1,  2};
    tbl[2] = '{4,  13,  -1,  1,    1,  0,   0,  1,   0,  0};
    tbl[3] = '{1,   8,  -1,  0,    1,  1,   1,  1,   0,  0};
    tbl[4] = '{2,  12,  -1,  1,    1,  0,   0,  1,   0,  0};

    for (int i = 0; i < 5; i++) begin
      w0 = wr_cnt; d0 = done_cnt; dw0 = done_wr;
      arm_capture(1'b0, tbl[i].cap);
      feed(tbl[i].nsamp, tbl[i].full_word < 0 ? -1 : tbl[i].full_word*8 + 7);
      if (tbl[i].do_abort) begin
        abort_r = 1'b1;
        @(negedge clk); abort_r = 1'b0;
      end
      repeat (4) @(negedge clk);
      #1;
      check($sformatf("v%0d_writes", i), 128'(wr_cnt - w0), 128'(tbl[i].exp_wr));
      check($sformatf("v%0d_done", i), 128'(done_cnt - d0), 128'(tbl[i].exp_done));
      check($sformatf("v%0d_done_with_wr", i), 128'(done_wr - dw0), 128'(tbl[i].exp_done_wr));
      check($sformatf("v%0d_wcnt", i), 128'(word_cnt), 128'(tbl[i].exp_wcnt));
      check($sformatf("v%0d_ovf", i), 128'(ovf), 128'(tbl[i].exp_ovf));
      check($sformatf("v%0d_busy", i), 128'(busy), 0);
      check($sformatf("v%0d_first", i), wr_log[w0 % 256], exp_word(0));
      check($sformatf("v%0d_last", i), wr_log[(w0 + tbl[i].exp_wr - 1) % 256],
            exp_word(tbl[i].last_idx));
    end

    // Trigger mode: valid samples while waiting must be ignored, edge-cycle sample skipped.
    w0 = wr_cnt; d0 = done_cnt;
    arm_capture(1'b1, 1);
    repeat (20) begin
      @(negedge clk); adc_valid = 1'b1; adc_data = 12'hAAA;
    end
    #1;
    check("trig_no_early_write", 128'(wr_cnt - w0), 0);
    check("trig_busy_armed", 128'(busy), 1);
    @(negedge clk); trig = 1'b1; adc_data = 12'hBBB;
    feed(8, -1);
    trig = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("trig_writes", 128'(wr_cnt - w0), 1);
    check("trig_data", wr_log[w0 % 256], exp_word(0));
    check("trig_done", 128'(done_cnt - d0), 1);
    check("trig_busy", 128'(busy), 0);

    // Continuous capture: 17 words through a 4-bit counter.
    w0 = wr_cnt; d0 = done_cnt;
    arm_capture(1'b0, 0);
    feed(136, -1);
    repeat (4) @(negedge clk);
    #1;
    check("wrap_writes", 128'(wr_cnt - w0), 17);
    check("wrap_wcnt", 128'(word_cnt), 1);
    check("wrap_no_done", 128'(done_cnt - d0), 0);
    check("wrap_busy", 128'(busy), 1);
    check("wrap_last", wr_log[(w0 + 16) % 256], exp_word(16));
    @(negedge clk); abort_r = 1'b1;
    @(negedge clk); abort_r = 1'b0;
    #1;
    check("wrap_abort_busy", 128'(busy), 0);

    // Reset mid-capture with 3 samples of word 2 pending.
    w0 = wr_cnt;
    arm_capture(1'b0, 3);
    for (int s = 0; s < 11; s++) begin
      @(negedge clk); adc_valid = 1'b1; adc_data = AW'(s + 1);
    end
    @(negedge clk); adc_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    check("mrst_wren", wren, 0);
    check("mrst_data", wdata, 0);
    check("mrst_busy", busy, 0);
    check("mrst_wcnt", word_cnt, 0);
    check("mrst_done", done, 0);
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk); adc_valid = 1'b1; adc_data = AW'(s + 1);
    end
    @(negedge clk); adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mrst_writes", 128'(wr_cnt - w0), 1);
    check("mrst_idle_busy", 128'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
